// File: rtl/i2s_pkg.sv
// i2s_pkg
// Shared types and default sizes for the I2S transmitter.
//   i2s_mode_e       : I2S_PHILIPS (data one bit after the word_select edge) or
//                      I2S_LEFT_JUST (data aligned with the word_select edge)
//   I2S_SAMPLE_W_DEF : default bits per channel sample
//   I2S_SLOT_W_DEF   : default bit clocks per channel slot
package i2s_pkg;

  typedef enum logic {
    I2S_PHILIPS   = 1'b0,
    I2S_LEFT_JUST = 1'b1
  } i2s_mode_e;

  localparam int I2S_SAMPLE_W_DEF = 16;
  localparam int I2S_SLOT_W_DEF   = 32;

endpackage

// File: rtl/i2s_slot_counter.sv
// i2s_slot_counter
// Free-running frame position counter, 0 .. 2*SLOT_W-1, wrapping to 0.
// Ports:
//   serial_clk : bit clock, rising edge
//   reset      : synchronous, active-low
//   count      : registered frame position (the visible bit_counter)
//   count_nxt  : value count takes on the next edge, so the owner can
//                register other outputs aligned with count
//   last_bit   : registered, high while count == 2*SLOT_W-1
//   slot       : registered, high while count >= SLOT_W (right channel)
module i2s_slot_counter
  import i2s_pkg::*;
#(
  parameter int SLOT_W = I2S_SLOT_W_DEF,
  parameter int CNT_W  = $clog2(2*SLOT_W)
) (
  input  logic             serial_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             last_bit,
  output logic             slot
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(2*SLOT_W-1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(SLOT_W);

  always_comb begin
    count_nxt = (count == LAST) ? '0 : count + CNT_W'(1);
  end

  // strobes are derived from count_nxt so they line up with count
  always_ff @(posedge serial_clk) begin
    if (!reset) begin
      count    <= '0;
      last_bit <= 1'b0;
      slot     <= 1'b0;
    end else begin
      count    <= count_nxt;
      last_bit <= (count_nxt == LAST);
      slot     <= (count_nxt >= HALF);
    end
  end

endmodule

// File: rtl/i2s_tx_param.sv
// i2s_tx_param
// Parametrised I2S serial transmitter. Stereo PCM frames are accepted through a
// valid/ready handshake once per frame and shifted out MSB-first.
// Build option: define I2S_TX_HOLD_ON_UNDERRUN_EN to repeat the last frame on an
// underrun; by default an underrun produces a silent (all-zero) frame.
// Ports:
//   serial_clk    : bit clock, all logic on its rising edge
//   reset         : synchronous, active-low
//   s_valid       : source holds a frame
//   s_ready       : capture strobe, high while bit_counter == 2*SLOT_W-1
//   s_left        : left sample, two's complement, SAMPLE_W bits
//   s_right       : right sample, two's complement, SAMPLE_W bits
//   word_select   : 0 = left slot, 1 = right slot
//   sound_bit_out : serial data
//   bit_counter   : position in frame, 0 .. 2*SLOT_W-1
//   underrun      : one-cycle pulse at c = 0 when no frame was available
module i2s_tx_param
  import i2s_pkg::*;
#(
  parameter int        SAMPLE_W = I2S_SAMPLE_W_DEF,
  parameter int        SLOT_W   = I2S_SLOT_W_DEF,
  parameter i2s_mode_e MODE     = I2S_PHILIPS
) (
  input  logic                          serial_clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [SAMPLE_W-1:0]    s_left,
  input  logic signed [SAMPLE_W-1:0]    s_right,
  output logic                          word_select,
  output logic                          sound_bit_out,
  output logic [$clog2(2*SLOT_W)-1:0]   bit_counter,
  output logic                          underrun
);

  localparam int CNT_W = $clog2(2*SLOT_W);

  if (SAMPLE_W < 8 || SAMPLE_W > 32) begin : g_bad_sample_w
    $error("i2s_tx_param: SAMPLE_W=%0d outside 8..32", SAMPLE_W);
  end
  if (SLOT_W < SAMPLE_W || SLOT_W < 8) begin : g_bad_slot_w
    $error("i2s_tx_param: SLOT_W=%0d must be >= SAMPLE_W and >= 8", SLOT_W);
  end

  // Left-justified stream bit for frame position c. Shifting the sample left by
  // the in-slot position puts the wanted bit at the MSB; positions past the
  // sample width shift everything out, giving the zero padding for free.
  function automatic logic stream_bit(input logic [CNT_W-1:0]        c,
                                      input logic signed [SAMPLE_W-1:0] l,
                                      input logic signed [SAMPLE_W-1:0] r);
    logic [CNT_W-1:0]    pos;
    logic [SAMPLE_W-1:0] sh;
    if (c >= CNT_W'(SLOT_W)) begin
      pos = c - CNT_W'(SLOT_W);
      sh  = $unsigned(r) << pos;
    end else begin
      pos = c;
      sh  = $unsigned(l) << pos;
    end
    return sh[SAMPLE_W-1];
  endfunction

  logic [CNT_W-1:0]           cnt_nxt;
  logic                       last_bit;
  logic                       slot;
  logic signed [SAMPLE_W-1:0] left_p0, right_p0;
  logic signed [SAMPLE_W-1:0] left_nxt, right_nxt;
  logic                       under_nxt;
  logic                       lj_p0;
  logic                       lj_nxt;
  logic                       sdo_nxt;

  i2s_slot_counter #(
    .SLOT_W (SLOT_W),
    .CNT_W  (CNT_W)
  ) u_slot_counter (
    .serial_clk (serial_clk),
    .reset      (reset),
    .count      (bit_counter),
    .count_nxt  (cnt_nxt),
    .last_bit   (last_bit),
    .slot       (slot)
  );

  assign s_ready     = last_bit;
  assign word_select = slot;

  always_comb begin
    left_nxt  = left_p0;
    right_nxt = right_p0;
    under_nxt = 1'b0;
    if (s_ready) begin
      if (s_valid) begin
        left_nxt  = s_left;
        right_nxt = s_right;
      end else begin
        under_nxt = 1'b1;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
        // keep the previous frame so it repeats
`else
        left_nxt  = '0;
        right_nxt = '0;
`endif
      end
    end
    // the new frame is already in left_nxt/right_nxt when cnt_nxt wraps to 0,
    // so the final bit of the old frame and a capture never collide
    lj_nxt  = stream_bit(cnt_nxt, left_nxt, right_nxt);
    sdo_nxt = (MODE == I2S_LEFT_JUST) ? lj_nxt : lj_p0;
  end

  // stage p0: frame register, one-bit Philips delay and serial output
  always_ff @(posedge serial_clk) begin
    if (!reset) begin
      left_p0       <= '0;
      right_p0      <= '0;
      lj_p0         <= 1'b0;
      sound_bit_out <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      left_p0       <= left_nxt;
      right_p0      <= right_nxt;
      lj_p0         <= lj_nxt;
      sound_bit_out <= sdo_nxt;
      underrun      <= under_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_tx_param.sv
// tb_i2s_tx_param
// Directed bench for i2s_tx_param: Philips and left-justified 16/32 instances
// share stimulus; a 24/24 Philips instance covers the full-slot corner.
module tb_i2s_tx_param;
  import i2s_pkg::*;

`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic serial_clk = 1'b0;
  logic reset;
  logic s_valid, s_valid_w;
  logic signed [15:0] s_left, s_right;
  logic signed [23:0] s_left_w, s_right_w;

  logic rdy_p, ws_p, sdo_p, und_p;
  logic rdy_l, ws_l, sdo_l, und_l;
  logic rdy_w, ws_w, sdo_w, und_w;
  logic [5:0] cnt_p, cnt_l, cnt_w;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          c0;
    logic [15:0] p_bits;
    logic [15:0] l_bits;
    logic        ws;
  } seg_t;
  seg_t segs[4];

  always #5 serial_clk = ~serial_clk;

  i2s_tx_param #(.SAMPLE_W(16), .SLOT_W(32), .MODE(I2S_PHILIPS)) dut_p (
    .serial_clk(serial_clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy_p),
    .s_left(s_left), .s_right(s_right), .word_select(ws_p),
    .sound_bit_out(sdo_p), .bit_counter(cnt_p), .underrun(und_p));

  i2s_tx_param #(.SAMPLE_W(16), .SLOT_W(32), .MODE(I2S_LEFT_JUST)) dut_l (
    .serial_clk(serial_clk), .reset(reset), .s_valid(s_valid), .s_ready(rdy_l),
    .s_left(s_left), .s_right(s_right), .word_select(ws_l),
    .sound_bit_out(sdo_l), .bit_counter(cnt_l), .underrun(und_l));

  i2s_tx_param #(.SAMPLE_W(24), .SLOT_W(24), .MODE(I2S_PHILIPS)) dut_w (
    .serial_clk(serial_clk), .reset(reset), .s_valid(s_valid_w), .s_ready(rdy_w),
    .s_left(s_left_w), .s_right(s_right_w), .word_select(ws_w),
    .sound_bit_out(sdo_w), .bit_counter(cnt_w), .underrun(und_w));

  task automatic chk1(input string name, input int c, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at c=%0d: got %b want %b", name, c, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge serial_clk);
    @(negedge serial_clk);
  endtask

  task automatic wait_cp(input int target);
    int n;
    n = 0;
    while (int'(cnt_p) != target && n < 300) begin
      tick();
      n++;
    end
    chkn("wait_bit_counter", int'(cnt_p), target);
  endtask

  task automatic wait_cw(input int target);
    int n;
    n = 0;
    while (int'(cnt_w) != target && n < 300) begin
      tick();
      n++;
    end
    chkn("wait_bit_counter_w", int'(cnt_w), target);
  endtask

  // Walks one full 16/32 frame starting at c=0, comparing both modes against
  // the A5F0/0F0F table (or silence). Optionally raises s_valid at c=10 and
  // changes the data at c=40. Returns at c=63 without advancing.
  task automatic check_frame(input bit zero_exp, input bit change_mid);
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 16; b++) begin
        int          c;
        logic [15:0] tp, tl;
        c  = segs[s].c0 + b;
        tp = segs[s].p_bits << b;
        tl = segs[s].l_bits << b;
        chkn("bit_counter", int'(cnt_p), c);
        chk1("sdo_philips", c, sdo_p, zero_exp ? 1'b0 : tp[15]);
        chk1("sdo_leftjust", c, sdo_l, zero_exp ? 1'b0 : tl[15]);
        chk1("word_select_p", c, ws_p, segs[s].ws);
        chk1("word_select_l", c, ws_l, segs[s].ws);
        chk1("s_ready", c, rdy_p, c == 63);
        if (c != 0) chk1("underrun_idle", c, und_p, 1'b0);
        if (change_mid && c == 10) begin
          s_valid = 1'b1;
          s_left  = 16'sh1111;
          s_right = 16'sh2222;
        end
        if (change_mid && c == 40) begin
          s_left  = 16'sh8001;
          s_right = 16'sh7FFE;
        end
        if (c != 63) tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Frame after capture of L=A5F0 R=0F0F, 16 cycles per row.
    // Philips is the left-justified stream delayed by one bit.
    segs[0] = '{0,  16'h52F8, 16'hA5F0, 1'b0};
    segs[1] = '{16, 16'h0000, 16'h0000, 1'b0};
    segs[2] = '{32, 16'h0787, 16'h0F0F, 1'b1};
    segs[3] = '{48, 16'h8000, 16'h0000, 1'b1};

    reset     = 1'b0;
    s_valid   = 1'b0;
    s_valid_w = 1'b1;
    s_left    = '0;
    s_right   = '0;
    s_left_w  = 24'sh000000;
    s_right_w = 24'sh000001;

    // power-up reset
    tick();
    tick();
    chkn("reset_cnt", int'(cnt_p), 0);
    chk1("reset_ready", 0, rdy_p, 1'b0);
    chk1("reset_sdo", 0, sdo_p, 1'b0);

    // Philips / left-justified main frame
    reset   = 1'b1;
    s_valid = 1'b1;
    s_left  = 16'shA5F0;
    s_right = 16'sh0F0F;
    wait_cp(63);
    chk1("ready_first", 63, rdy_p, 1'b1);
    chk1("ready_first_l", 63, rdy_l, 1'b1);
    chk1("first_frame_silent", 63, sdo_l, 1'b0);
    tick();
    chk1("no_underrun_first", 0, und_p, 1'b0);
    check_frame(1'b0, 1'b0);

    // underrun: s_valid low at the capture cycle
    s_valid = 1'b0;
    tick();
    chk1("underrun_pulse_p", 0, und_p, 1'b1);
    chk1("underrun_pulse_l", 0, und_l, 1'b1);
    check_frame(!HOLD, 1'b1);

    // frame captured at c=63 after late s_valid and mid-frame data change
    tick();
    chk1("late_no_underrun", 0, und_p, 1'b0);
    chk1("late_l_c0", 0, sdo_l, 1'b1);
    chk1("late_p_c0", 0, sdo_p, 1'b0);
    tick();
    chk1("late_l_c1", 1, sdo_l, 1'b0);
    chk1("late_p_c1", 1, sdo_p, 1'b1);
    wait_cp(15);
    chk1("late_l_c15", 15, sdo_l, 1'b1);
    tick();
    chk1("late_p_c16", 16, sdo_p, 1'b1);
    chk1("late_l_c16", 16, sdo_l, 1'b0);
    wait_cp(32);
    chk1("late_l_c32", 32, sdo_l, 1'b0);
    chk1("late_ws_c32", 32, ws_p, 1'b1);
    tick();
    chk1("late_l_c33", 33, sdo_l, 1'b1);
    chk1("late_p_c33", 33, sdo_p, 1'b0);
    wait_cp(47);
    chk1("late_l_c47", 47, sdo_l, 1'b0);
    chk1("late_p_c47", 47, sdo_p, 1'b1);

    // mid-frame reset at c=40
    wait_cp(40);
    chk1("pre_reset_l", 40, sdo_l, 1'b1);
    reset = 1'b0;
    tick();
    tick();
    tick();
    chkn("rst_cnt_p", int'(cnt_p), 0);
    chkn("rst_cnt_w", int'(cnt_w), 0);
    chk1("rst_ws_p", 0, ws_p, 1'b0);
    chk1("rst_sdo_p", 0, sdo_p, 1'b0);
    chk1("rst_sdo_l", 0, sdo_l, 1'b0);
    chk1("rst_ready_p", 0, rdy_p, 1'b0);
    chk1("rst_underrun_p", 0, und_p, 1'b0);
    chk1("rst_ws_w", 0, ws_w, 1'b0);
    chk1("rst_sdo_w", 0, sdo_w, 1'b0);
    reset = 1'b1;
    tick();
    chkn("restart_c1", int'(cnt_p), 1);
    tick();
    chkn("restart_c2", int'(cnt_p), 2);
    tick();
    chkn("restart_c3", int'(cnt_p), 3);
    for (int c = 3; c < 64; c++) begin
      chk1("post_reset_silent_p", c, sdo_p, 1'b0);
      chk1("post_reset_silent_l", c, sdo_l, 1'b0);
      chk1("post_reset_underrun", c, und_p, 1'b0);
      if (c != 63) tick();
    end
    chk1("post_reset_ready", 63, rdy_p, 1'b1);
    tick();
    chk1("post_reset_no_underrun", 0, und_p, 1'b0);
    chk1("post_reset_l_msb", 0, sdo_l, 1'b1);

    // SAMPLE_W = SLOT_W = 24: right LSB lands at c=0 of the next frame
    wait_cw(47);
    chk1("w_ready_c47", 47, rdy_w, 1'b1);
    chk1("w_ws_c47", 47, ws_w, 1'b1);
    chk1("w_sdo_c47", 47, sdo_w, 1'b0);
    tick();
    chkn("w_cnt_wrap", int'(cnt_w), 0);
    chk1("w_sdo_c0", 0, sdo_w, 1'b1);
    chk1("w_ws_c0", 0, ws_w, 1'b0);
    tick();
    chk1("w_sdo_c1", 1, sdo_w, 1'b0);
    chk1("w_underrun", 1, und_w, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_param.md
# i2s_tx_param

Parametrised I2S serial transmitter: accepts stereo PCM frames through a valid/ready handshake and shifts them out MSB-first on `sound_bit_out`, with `word_select` marking the channel. Sample width, slot width and justification mode are parameters. Missing input frames are reported as underruns. Sits between the audio processing pipeline and the external DAC, clocked directly by the serial bit clock.

## Interface
- `SAMPLE_W`, 16: bits per channel sample; legal range 8..32.
- `SLOT_W`, 32: bit clocks per channel slot; must be ≥ `SAMPLE_W` and ≥ 8.
- `MODE`, `I2S_PHILIPS`: `I2S_PHILIPS` (data one bit after the `word_select` edge) or `I2S_LEFT_JUST` (data aligned with the edge).
- `serial_clk` in 1: bit clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `s_valid` in 1: source holds a frame.
- `s_ready` out 1: frame capture strobe.
- `s_left` in `SAMPLE_W`: left sample, two's complement.
- `s_right` in `SAMPLE_W`: right sample.
- `word_select` out 1: 0 = left slot, 1 = right slot.
- `sound_bit_out` out 1: serial data.
- `bit_counter` out `$clog2(2*SLOT_W)`: position in frame.
- `underrun` out 1: one-cycle pulse, no frame available at capture.

## Operation
- `bit_counter` counts 0..2*SLOT_W-1 and wraps to 0. It is free-running out of reset.
- Let c be the visible `bit_counter`. Then `word_select` = (c ≥ SLOT_W).
- Left-justified stream bit L(c): sample bit [SAMPLE_W-1-(c mod SLOT_W)] of the active channel if (c mod SLOT_W) < SAMPLE_W, else 0.
- `I2S_LEFT_JUST`: `sound_bit_out` = L(c).
- `I2S_PHILIPS`: `sound_bit_out` = L(c) of the previous cycle. The last bit of one frame therefore appears at c = 0 of the next frame, which matters when SAMPLE_W = SLOT_W.
- Handshake:
  - `s_ready` is high exactly in cycles where c = 2*SLOT_W-1.
  - If `s_valid` is also high, {`s_left`,`s_right`} are captured into the frame register, which is active from the next cycle (c = 0).
  - `s_valid` in any other cycle is ignored. The source holds its data until accepted.
- Underrun: `s_valid` low when `s_ready` is high → `underrun` pulses during the following c = 0 cycle. The frame register is loaded per the Configuration section.
- Reset (any cycle, including mid-frame): on the next edge, all of the following go to 0:
  - `bit_counter`, `word_select`, `sound_bit_out`, `s_ready`, `underrun`
  - frame register
  - the one-bit I2S delay register
- The first frame after reset is silence and raises no underrun.

## Timing
- Frame period is 2*SLOT_W serial_clk cycles; latency from capture to left MSB:
  - 1 cycle in `I2S_LEFT_JUST`.
  - 2 cycles in `I2S_PHILIPS`.
- All outputs are registered, with no combinational path from inputs to outputs.
- `word_select` changes only on edges where c becomes 0 or SLOT_W.
- A capture and the transmission of the previous frame's final bit occur in the same cycle without interference.

## Configuration
- `I2S_TX_HOLD_ON_UNDERRUN_EN` defined: on underrun the frame register keeps its previous contents, so the last frame repeats.
- Undefined: on underrun the frame register is loaded with zeros, giving silence.
- `underrun` pulses in both builds.

## Structure
- Package `i2s_pkg` holds:
  - enum `i2s_mode_e` {`I2S_PHILIPS`=0, `I2S_LEFT_JUST`=1}.
  - default constants `I2S_SAMPLE_W_DEF`=16 and `I2S_SLOT_W_DEF`=32.
- Sub-module `i2s_slot_counter`: wrapping frame counter with synchronous reset. It produces `bit_counter`, the last-bit strobe and the slot flag.
- Elaboration-time assertions enforce the legal parameter ranges.

## Test plan
All scenarios use SAMPLE_W=16, SLOT_W=32 unless stated otherwise.
- Reset low for 3 cycles at c=40 → after the next edge all outputs are 0. The counter restarts 0,1,2… after release.
- `I2S_PHILIPS`, `s_valid` held, L=0xA5F0, R=0x0F0F → `s_ready` pulses at c=63. In the next frame:
  - `sound_bit_out` at c=1..16 = 1010010111110000, and 0 at c=17..32.
  - c=33..48 = 0000111100001111.
  - `word_select` is 1 from c=32.
- Same data with `I2S_LEFT_JUST` → left MSB at c=0, right MSB at c=32, zeros at c=16..31.
- `s_valid` low at c=63 after a frame of 0xA5F0/0x0F0F → `underrun` is high for one cycle at c=0. The next frame is:
  - all zeros with the macro off;
  - repeated 0xA5F0/0x0F0F with the macro on.
- SAMPLE_W=SLOT_W=24, `I2S_PHILIPS`, R=0x000001 → right LSB of 1 appears at c=0 of the next frame with `word_select`=0.
- `s_valid` raised at c=10 → `s_ready` stays low until c=63 and capture happens there. Data changed before c=63 is what gets captured.
